// File: rtl/rgb_status_led.sv
// rgb_status_led: boot/idle/active/fault status indicator that drives a common-anode RGB LED.
// All three LED pins are active-low and PWM-dimmed.
// Optional build macro LED_STATUS_GAMMA_EN: squares each duty value (gamma correction) and
// adds one pipeline stage, so the pin latency grows from 1 clk to 2 clk.
module rgb_status_led #(
    parameter int unsigned PWM_BITS      = 8,
    parameter int unsigned TICK_DIV      = 12000,
    parameter int unsigned STRETCH_TICKS = 50,
    parameter int unsigned BLINK_TICKS   = 250
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                step_pulse,
    input  logic                error_set,
    input  logic                error_clr,
    input  logic [PWM_BITS-1:0] idle_brightness,
    output logic                led_red,
    output logic                led_green,
    output logic                led_blue,
    output logic [1:0]          state_o
);

    localparam int unsigned DivW     = $clog2(TICK_DIV);
    localparam int unsigned StretchW = $clog2(STRETCH_TICKS + 1);
    localparam int unsigned BlinkW   = $clog2(BLINK_TICKS + 1);

    typedef enum logic [1:0] {StBoot = 2'd0, StIdle = 2'd1, StActive = 2'd2, StFault = 2'd3}
        state_e;

    state_e              state_q, state_d;
    logic [DivW-1:0]     div_cnt_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [PWM_BITS-1:0] boot_cnt_q, boot_cnt_d;
    logic [StretchW-1:0] stretch_cnt_q, stretch_cnt_d;
    logic [BlinkW-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic                tick;
    logic [PWM_BITS-1:0] duty_r, duty_g, duty_b;
    logic [PWM_BITS-1:0] eff_r, eff_g, eff_b;

    assign tick    = (div_cnt_q == DivW'(TICK_DIV - 1));
    assign state_o = state_q;

    // Free-running tick divider and PWM ramp.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
            pwm_cnt_q <= '0;
        end else begin
            div_cnt_q <= tick ? '0 : div_cnt_q + 1'b1;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
        end
    end

    // FSM and indication counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StBoot;
            boot_cnt_q    <= '0;
            stretch_cnt_q <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            boot_cnt_q    <= boot_cnt_d;
            stretch_cnt_q <= stretch_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end

    // Next state: error_set > error_clr > step_pulse > tick-driven transitions.
    always_comb begin
        state_d       = state_q;
        boot_cnt_d    = boot_cnt_q;
        stretch_cnt_d = stretch_cnt_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (error_set) begin
            // Re-asserting while already in FAULT restarts the blink.
            state_d       = StFault;
            blink_phase_d = 1'b1;
            blink_cnt_d   = '0;
        end else if (error_clr && state_q == StFault) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StBoot: begin
                    if (tick) begin
                        boot_cnt_d = boot_cnt_q + 1'b1;
                        if (boot_cnt_q == '1) state_d = StIdle;
                    end
                end
                StIdle: begin
                    if (step_pulse) begin
                        state_d       = StActive;
                        stretch_cnt_d = StretchW'(STRETCH_TICKS);
                    end
                end
                StActive: begin
                    if (step_pulse) begin
                        stretch_cnt_d = StretchW'(STRETCH_TICKS);
                    end else if (tick) begin
                        if (stretch_cnt_q <= StretchW'(1)) begin
                            stretch_cnt_d = '0;
                            state_d       = StIdle;
                        end else begin
                            stretch_cnt_d = stretch_cnt_q - 1'b1;
                        end
                    end
                end
                StFault: begin
                    if (tick) begin
                        if (blink_cnt_q == BlinkW'(BLINK_TICKS - 1)) begin
                            blink_cnt_d   = '0;
                            blink_phase_d = ~blink_phase_q;
                        end else begin
                            blink_cnt_d = blink_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = StBoot;
            endcase
        end
    end

    // Per-state channel duty selection.
    always_comb begin
        duty_r = '0;
        duty_g = '0;
        duty_b = '0;
        unique case (state_q)
            StBoot:   duty_b = boot_cnt_q;
            StIdle:   duty_g = idle_brightness;
            StActive: duty_b = '1;
            StFault:  duty_r = blink_phase_q ? '1 : '0;
            default:  duty_b = '0;
        endcase
    end

`ifdef LED_STATUS_GAMMA_EN
    // Square-law curve; full scale is pinned so "max" stays max.
    function automatic logic [PWM_BITS-1:0] gamma(input logic [PWM_BITS-1:0] d);
        logic [2*PWM_BITS-1:0] prod;
        prod = {{PWM_BITS{1'b0}}, d} * {{PWM_BITS{1'b0}}, d};
        if (d == '1) return '1;
        return prod[2*PWM_BITS-1:PWM_BITS];
    endfunction

    // Pipeline register on the corrected duty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eff_r <= '0;
            eff_g <= '0;
            eff_b <= '0;
        end else begin
            eff_r <= gamma(duty_r);
            eff_g <= gamma(duty_g);
            eff_b <= gamma(duty_b);
        end
    end
`else
    assign eff_r = duty_r;
    assign eff_g = duty_g;
    assign eff_b = duty_b;
`endif

    // Registered PWM compare; pins are active-low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_red   <= 1'b1;
            led_green <= 1'b1;
            led_blue  <= 1'b1;
        end else begin
            led_red   <= !(pwm_cnt_q < eff_r);
            led_green <= !(pwm_cnt_q < eff_g);
            led_blue  <= !(pwm_cnt_q < eff_b);
        end
    end

endmodule

// File: tb/tb_rgb_status_led.sv
// tb_rgb_status_led: directed bench for rgb_status_led, small parameters.
// cyc counts rising edges since the last reset release, and every sample is taken at a falling edge.
module tb_rgb_status_led;

`ifdef LED_STATUS_GAMMA_EN
    localparam int Lat = 2;
    localparam int Eff8 = 4;
`else
    localparam int Lat = 1;
    localparam int Eff8 = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       step_pulse = 1'b0;
    logic       error_set = 1'b0;
    logic       error_clr = 1'b0;
    logic [3:0] idle_brightness = 4'd4;
    logic       led_red, led_green, led_blue;
    logic [1:0] state_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    rgb_status_led #(
        .PWM_BITS     (4),
        .TICK_DIV     (4),
        .STRETCH_TICKS(3),
        .BLINK_TICKS  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .step_pulse     (step_pulse),
        .error_set      (error_set),
        .error_clr      (error_clr),
        .idle_brightness(idle_brightness),
        .led_red        (led_red),
        .led_green      (led_green),
        .led_blue       (led_blue),
        .state_o        (state_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        int guard = 0;
        while (cyc != n && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != n) check("wait_cyc", cyc, n);
    endtask

    initial begin
        int lows_r, lows_g, lows_b, bad;

        // 1: asynchronous reset between edges, then the BOOT duration.
        #32 rst = 1'b1;
        #1;
        check("rst_red", led_red, 1);
        check("rst_green", led_green, 1);
        check("rst_blue", led_blue, 1);
        check("rst_state", state_o, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(63);
        check("boot_end_state", state_o, 0);
        wait_cyc(64);
        check("idle_entry_state", state_o, 1);

        // 2: IDLE green dimming at duty 4, then at duty 0.
        lows_r = 0; lows_g = 0; lows_b = 0;
        for (int k = 66; k <= 81; k++) begin
            wait_cyc(k);
            if (!led_red) lows_r++;
            if (!led_green) lows_g++;
            if (!led_blue) lows_b++;
        end
        check("idle4_green_lows", lows_g, 4);
        check("idle4_red_lows", lows_r, 0);
        check("idle4_blue_lows", lows_b, 0);
        idle_brightness = 4'd0;
        lows_g = 0;
        for (int k = 84; k <= 99; k++) begin
            wait_cyc(k);
            if (!led_green) lows_g++;
        end
        check("idle0_green_lows", lows_g, 0);

        // 6: duty 8, linear or gamma-corrected, checked against the PWM phase.
        idle_brightness = 4'd8;
        lows_g = 0; bad = 0;
        for (int k = 102; k <= 117; k++) begin
            wait_cyc(k);
            if (!led_green) lows_g++;
            if (led_green !== !(((k - 1) % 16) < Eff8)) bad++;
        end
        check("idle8_green_lows", lows_g, Eff8);
        check("idle8_green_phase_errs", bad, 0);

        // 3: single step pulse, then a reload on the second tick.
        wait_cyc(120);
        step_pulse = 1'b1;
        wait_cyc(121);
        step_pulse = 1'b0;
        check("step_enter_active", state_o, 2);
        wait_cyc(131);
        check("active_hold", state_o, 2);
        wait_cyc(132);
        check("active_expire", state_o, 1);
        wait_cyc(136);
        step_pulse = 1'b1;
        wait_cyc(137);
        step_pulse = 1'b0;
        check("step2_enter_active", state_o, 2);
        lows_r = 0; lows_g = 0; lows_b = 0;
        for (int k = 139; k <= 154; k++) begin
            wait_cyc(k);
            if (!led_red) lows_r++;
            if (!led_green) lows_g++;
            if (!led_blue) lows_b++;
            if (k == 143) step_pulse = 1'b1;
            if (k == 144) step_pulse = 1'b0;
        end
        check("active_blue_lows", lows_b, 15);
        check("active_green_lows", lows_g, 0);
        check("active_red_lows", lows_r, 0);
        wait_cyc(155);
        check("extended_active_hold", state_o, 2);
        wait_cyc(156);
        check("extended_active_expire", state_o, 1);

        // 4: fault from ACTIVE, the blink pattern, set+clr together, then a clear.
        wait_cyc(160);
        step_pulse = 1'b1;
        wait_cyc(161);
        step_pulse = 1'b0;
        wait_cyc(164);
        error_set = 1'b1;
        wait_cyc(165);
        error_set = 1'b0;
        check("fault_entry", state_o, 3);
        bad = 0; lows_g = 0; lows_b = 0;
        for (int k = 167; k <= 189; k++) begin
            wait_cyc(k);
            if (led_red !== !(((((k - Lat) - 164) / 8) % 2 == 0) && (((k - 1) % 16) < 15)))
                bad++;
            if (!led_green) lows_g++;
            if (!led_blue) lows_b++;
        end
        check("fault_red_blink_errs", bad, 0);
        check("fault_green_lows", lows_g, 0);
        check("fault_blue_lows", lows_b, 0);
        wait_cyc(190);
        error_set = 1'b1;
        error_clr = 1'b1;
        wait_cyc(191);
        error_set = 1'b0;
        error_clr = 1'b0;
        check("set_and_clr_stay_fault", state_o, 3);
        wait_cyc(195);
        error_clr = 1'b1;
        wait_cyc(196);
        error_clr = 1'b0;
        check("clr_to_idle", state_o, 1);

        // 5: step and error in the same clock from IDLE.
        wait_cyc(200);
        step_pulse = 1'b1;
        error_set = 1'b1;
        wait_cyc(201);
        step_pulse = 1'b0;
        error_set = 1'b0;
        check("step_plus_error_fault", state_o, 3);
        error_clr = 1'b1;
        wait_cyc(202);
        error_clr = 1'b0;
        check("clr_again_idle", state_o, 1);

        // Reset mid-operation, then a step pulse during BOOT.
        wait_cyc(204);
        #2 rst = 1'b1;
        #1;
        check("rst2_red", led_red, 1);
        check("rst2_green", led_green, 1);
        check("rst2_blue", led_blue, 1);
        check("rst2_state", state_o, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_cyc(10);
        step_pulse = 1'b1;
        wait_cyc(11);
        step_pulse = 1'b0;
        check("boot_ignores_step", state_o, 0);
        check("boot_red_off", led_red, 1);
        wait_cyc(63);
        check("boot2_end_state", state_o, 0);
        wait_cyc(64);
        check("boot2_idle_state", state_o, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
